// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg
// Shared definitions for the product accumulator.
//   state_t      : accumulator FSM states (ACCUM accepting products, HOLD sum presented)
//   P_W, ACC_W   : default product / accumulator widths, also used by the multiplier's bench
//   cnt_width()  : term-counter width for a given number of terms, never below 1 bit
package prod_acc_pkg;

    localparam int P_W   = 8;
    localparam int ACC_W = 10;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int cnt_width(input int n_terms);
        return (n_terms > 1) ? $clog2(n_terms) : 1;
    endfunction

endpackage

// File: rtl/acc_term_counter.sv
// acc_term_counter
// Counts accepted products within one block and flags the last one.
//   clk    in  : clock, rising edge
//   reset  in  : synchronous active-high reset, count returns to 0
//   inc    in  : one product accepted this cycle
//   last   out : count == N_TERMS-1 (the next accepted product closes the block)
//   wrap   out : inc while last; the count returns to 0 on this edge
// N_TERMS must be at least 1. With N_TERMS = 1 the count is stuck at 0,
// so every accepted product is the last one.
module acc_term_counter #(
    parameter int N_TERMS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    output logic last,
    output logic wrap
);
    import prod_acc_pkg::*;

    localparam int CW = cnt_width(N_TERMS);
    localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    assign last = (count_reg == LAST_CNT);
    assign wrap = inc & last;

    always_comb begin
        count_next = count_reg;
        if (inc) begin
            // Wrapping at LAST_CNT keeps the count inside 0..N_TERMS-1 even
            // when N_TERMS is not a power of two.
            count_next = last ? '0 : count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator
// Sums blocks of N_TERMS unsigned products and presents each block sum over
// a valid/ready handshake. The carry out of ACC_W is flagged per block.
//   clk        in            : clock, rising edge
//   reset      in            : synchronous active-high reset, discards any partial or pending sum
//   p_in       in  [P_W]     : product, unsigned
//   p_valid    in            : p_in valid
//   p_ready    out           : product accepted when p_valid is also high (high only in ACCUM)
//   sum        out [ACC_W]   : finished block sum, wraps modulo 2^ACC_W, kept after the handshake
//   sum_ovf    out           : a carry out of ACC_W happened somewhere in this block
//   sum_valid  out           : sum / sum_ovf valid
//   sum_ready  in            : downstream takes the sum
// All outputs except p_ready are registers; p_ready depends only on the state,
// so neither p_valid nor sum_ready reaches an output combinationally.
module product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int P_W     = prod_acc_pkg::P_W,
    parameter int ACC_W   = prod_acc_pkg::ACC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [P_W-1:0]   p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic [ACC_W-1:0] sum,
    output logic             sum_ovf,
    output logic             sum_valid,
    input  logic             sum_ready
);
    import prod_acc_pkg::*;

    state_t           state_reg;
    state_t           state_next;
    logic [ACC_W-1:0] acc_reg;
    logic             ovf_reg;
    logic [ACC_W-1:0] sum_reg;
    logic             sum_ovf_reg;
    logic             sum_valid_reg;

    logic             accept;
    logic             cnt_last;
    logic             cnt_wrap;
    logic [ACC_W:0]   add_full;
    logic             carry;

    assign p_ready = (state_reg == ACCUM);
    assign accept  = p_valid & p_ready;

    // One extra bit captures the carry out of the accumulator width.
    assign add_full = {1'b0, acc_reg} + (ACC_W + 1)'(p_in);
    assign carry    = add_full[ACC_W];

    acc_term_counter #(
        .N_TERMS (N_TERMS)
    ) u_term_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .last  (cnt_last),
        .wrap  (cnt_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM: begin
                if (accept && cnt_last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (sum_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            sum_reg       <= '0;
            sum_ovf_reg   <= 1'b0;
            sum_valid_reg <= 1'b0;
        end else begin
            if (cnt_wrap) begin
                // Last term: the sum goes straight to the output register and
                // the accumulator starts the next block clean.
                sum_reg       <= add_full[ACC_W-1:0];
                sum_ovf_reg   <= ovf_reg | carry;
                sum_valid_reg <= 1'b1;
                acc_reg       <= '0;
                ovf_reg       <= 1'b0;
            end else if (accept) begin
                acc_reg <= add_full[ACC_W-1:0];
                ovf_reg <= ovf_reg | carry;
            end

            // cnt_wrap only happens in ACCUM, so this never collides with the
            // set above. sum_reg is deliberately left untouched.
            if ((state_reg == HOLD) && sum_ready) begin
                sum_valid_reg <= 1'b0;
            end
        end
    end

    assign sum       = sum_reg;
    assign sum_ovf   = sum_ovf_reg;
    assign sum_valid = sum_valid_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
// Three accumulators share one input stream: the default configuration
// (4 terms, 10-bit), a 2-term 8-bit one for wrap/overflow, and a 1-term one.
// The reference model keeps, per instance, the list of accepted products as a
// running integer total and count, and derives the sum and carry from plain
// arithmetic on the whole block.
module tb_product_accumulator;

    localparam int NT [3] = '{4, 2, 1};
    localparam int AW [3] = '{10, 8, 10};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p_valid = 1'b0;
    logic [7:0] p_in = 8'd0;
    logic       sum_ready = 1'b0;

    logic       p_ready0, p_ready1, p_ready2;
    logic       sum_ovf0, sum_ovf1, sum_ovf2;
    logic       sum_valid0, sum_valid1, sum_valid2;
    logic [9:0] sum0, sum2;
    logic [7:0] sum1;

    logic       p_ready_a [3];
    logic       sum_ovf_a [3];
    logic       sum_valid_a [3];
    logic [9:0] sum_a [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_hold  [3];
    int m_cnt   [3];
    int m_total [3];
    int m_sum   [3];
    bit m_ovf   [3];

    always #5 clk = ~clk;

    product_accumulator #(.N_TERMS(4), .P_W(8), .ACC_W(10)) dut0 (
        .clk(clk), .reset(reset), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready0),
        .sum(sum0), .sum_ovf(sum_ovf0), .sum_valid(sum_valid0), .sum_ready(sum_ready)
    );

    product_accumulator #(.N_TERMS(2), .P_W(8), .ACC_W(8)) dut1 (
        .clk(clk), .reset(reset), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready1),
        .sum(sum1), .sum_ovf(sum_ovf1), .sum_valid(sum_valid1), .sum_ready(sum_ready)
    );

    product_accumulator #(.N_TERMS(1), .P_W(8), .ACC_W(10)) dut2 (
        .clk(clk), .reset(reset), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready2),
        .sum(sum2), .sum_ovf(sum_ovf2), .sum_valid(sum_valid2), .sum_ready(sum_ready)
    );

    always_comb begin
        p_ready_a[0]   = p_ready0;
        p_ready_a[1]   = p_ready1;
        p_ready_a[2]   = p_ready2;
        sum_ovf_a[0]   = sum_ovf0;
        sum_ovf_a[1]   = sum_ovf1;
        sum_ovf_a[2]   = sum_ovf2;
        sum_valid_a[0] = sum_valid0;
        sum_valid_a[1] = sum_valid1;
        sum_valid_a[2] = sum_valid2;
        sum_a[0]       = sum0;
        sum_a[1]       = {2'b00, sum1};
        sum_a[2]       = sum2;
    end

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                m_hold[d]  = 1'b0;
                m_cnt[d]   = 0;
                m_total[d] = 0;
                m_sum[d]   = 0;
                m_ovf[d]   = 1'b0;
            end else if (!m_hold[d]) begin
                if (p_valid) begin
                    m_total[d] += int'(p_in);
                    m_cnt[d]++;
                    if (m_cnt[d] == NT[d]) begin
                        m_sum[d]   = m_total[d] % (1 << AW[d]);
                        m_ovf[d]   = (m_total[d] >= (1 << AW[d]));
                        m_hold[d]  = 1'b1;
                        m_cnt[d]   = 0;
                        m_total[d] = 0;
                    end
                end
            end else if (sum_ready) begin
                $display("dut%0d block handed over: sum=%0d ovf=%0b", d, m_sum[d], m_ovf[d]);
                m_hold[d] = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic cycle(input logic rst, input logic pv, input logic [7:0] pi, input logic sr);
        reset     = rst;
        p_valid   = pv;
        p_in      = pi;
        sum_ready = sr;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 8'd0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (p_ready_a[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_p_ready dut%0d: got %b want 1", d, p_ready_a[d]);
            end
            n_checks++;
            if (sum_valid_a[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_sum_valid dut%0d: got %b want 0", d, sum_valid_a[d]);
            end
            n_checks++;
            if (sum_a[d] !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_sum dut%0d: got %0d want 0", d, sum_a[d]);
            end
            n_checks++;
            if (sum_ovf_a[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_sum_ovf dut%0d: got %b want 0", d, sum_ovf_a[d]);
            end
        end
    endtask

    task automatic test_basic();
        cycle(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'd99, 1'b0);
            n_checks++;
            if (sum_valid0 !== (i == 3)) begin
                n_fail++;
                $display("FAIL basic_valid term%0d: got %b want %b", i, sum_valid0, (i == 3));
            end
            n_checks++;
            if (p_ready0 !== (i != 3)) begin
                n_fail++;
                $display("FAIL basic_p_ready term%0d: got %b want %b", i, p_ready0, (i != 3));
            end
        end
        n_checks++;
        if (sum0 !== 10'd396 || sum_ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_sum: got %0d/%b want 396/0", sum0, sum_ovf0);
        end
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
        n_checks++;
        if (sum_valid0 !== 1'b0 || p_ready0 !== 1'b1 || sum0 !== 10'd396) begin
            n_fail++;
            $display("FAIL basic_handshake: got valid=%b ready=%b sum=%0d want 0/1/396",
                     sum_valid0, p_ready0, sum0);
        end
    endtask

    task automatic test_gaps();
        bit pv_seq [7] = '{1, 0, 1, 0, 0, 1, 1};
        cycle(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, pv_seq[i], 8'd225, 1'b0);
            n_checks++;
            if (sum_valid0 !== (i == 6)) begin
                n_fail++;
                $display("FAIL gaps_valid step%0d: got %b want %b", i, sum_valid0, (i == 6));
            end
        end
        n_checks++;
        if (sum0 !== 10'd900 || sum_ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_sum: got %0d/%b want 900/0", sum0, sum_ovf0);
        end
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        int total = 0;
        cycle(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 225));
            total += int'(v);
            cycle(1'b0, 1'b1, v, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'd1, 1'b0);
            n_checks++;
            if (sum0 !== 10'(total) || sum_valid0 !== 1'b1 || p_ready0 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc%0d: got sum=%0d valid=%b ready=%b want %0d/1/0",
                         i, sum0, sum_valid0, p_ready0, total);
            end
        end
        cycle(1'b0, 1'b1, 8'd1, 1'b1);
        n_checks++;
        if (p_ready0 !== 1'b1 || sum_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got ready=%b valid=%b want 1/0", p_ready0, sum_valid0);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, 8'(i), 1'b0);
        end
        n_checks++;
        if (sum0 !== 10'd10 || sum_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_next_block: got sum=%0d valid=%b want 10/1", sum0, sum_valid0);
        end
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 8'd0, 1'b0);
        cycle(1'b0, 1'b1, 8'd50, 1'b0);
        cycle(1'b0, 1'b1, 8'd60, 1'b0);
        cycle(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, 8'(i), 1'b0);
            n_checks++;
            if (sum_valid0 !== (i == 4)) begin
                n_fail++;
                $display("FAIL rmid_valid term%0d: got %b want %b", i, sum_valid0, (i == 4));
            end
        end
        n_checks++;
        if (sum0 !== 10'd10) begin
            n_fail++;
            $display("FAIL rmid_sum: got %0d want 10", sum0);
        end
        // Reset together with a handshake while holding: reset wins, sum clears.
        cycle(1'b1, 1'b1, 8'd5, 1'b1);
        n_checks++;
        if (sum_valid0 !== 1'b0 || p_ready0 !== 1'b1 || sum0 !== 10'd0) begin
            n_fail++;
            $display("FAIL rhold: got valid=%b ready=%b sum=%0d want 0/1/0",
                     sum_valid0, p_ready0, sum0);
        end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0, 8'd0, 1'b0);
        cycle(1'b0, 1'b1, 8'd225, 1'b0);
        cycle(1'b0, 1'b1, 8'd225, 1'b0);
        n_checks++;
        if (sum1 !== 8'd194 || sum_ovf1 !== 1'b1 || sum_valid1 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_block: got sum=%0d ovf=%b valid=%b want 194/1/1",
                     sum1, sum_ovf1, sum_valid1);
        end
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
        cycle(1'b0, 1'b1, 8'd1, 1'b0);
        cycle(1'b0, 1'b1, 8'd1, 1'b0);
        n_checks++;
        if (sum1 !== 8'd2 || sum_ovf1 !== 1'b0 || sum_valid1 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_clear: got sum=%0d ovf=%b valid=%b want 2/0/1",
                     sum1, sum_ovf1, sum_valid1);
        end
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
    endtask

    task automatic test_single_term();
        logic [7:0] vals [4] = '{8'd3, 8'd7, 8'd9, 8'd0};
        int k = 0;
        cycle(1'b1, 1'b0, 8'd0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, 1'b1, vals[k], 1'b1);
            if (c % 2 == 0) begin
                n_checks++;
                if (sum_valid2 !== 1'b1 || sum2 !== 10'(vals[k]) || p_ready2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_accept c%0d: got valid=%b sum=%0d ready=%b want 1/%0d/0",
                             c, sum_valid2, sum2, p_ready2, vals[k]);
                end
                k++;
            end else begin
                n_checks++;
                if (sum_valid2 !== 1'b0 || p_ready2 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_bubble c%0d: got valid=%b ready=%b want 0/1",
                             c, sum_valid2, p_ready2);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 1'b0, 8'd0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) < 7),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 9) < 6));
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (p_ready_a[d] !== !m_hold[d] || sum_valid_a[d] !== m_hold[d]) begin
                    n_fail++;
                    $display("FAIL rnd_flags dut%0d c%0d: got ready=%b valid=%b want %b/%b",
                             d, c, p_ready_a[d], sum_valid_a[d], !m_hold[d], m_hold[d]);
                end
                n_checks++;
                if (sum_a[d] !== 10'(m_sum[d]) || sum_ovf_a[d] !== m_ovf[d]) begin
                    n_fail++;
                    $display("FAIL rnd_sum dut%0d c%0d: got %0d/%b want %0d/%b",
                             d, c, sum_a[d], sum_ovf_a[d], m_sum[d], m_ovf[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        test_single_term();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the serial multiplier's 8-bit product output. It sums a fixed number of products (a dot-product block) and presents each finished block sum to the next stage over a valid/ready handshake. Carry-out is flagged per block. Inputs are taken with a valid/ready handshake, so the multiplier, or a wrapper around it, can stall the stream.

## Interface
- `N_TERMS`, default 4: products per block; must be ≥ 1.
- `P_W`, default 8: product width; matches the multiplier's `P`.
- `ACC_W`, default 10: accumulator and sum width; must be ≥ `P_W`. The default holds 4 × 225 = 900 without overflow.
- `CLK`  in  1: single clock; all state changes on the rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `P_IN`  in  `P_W`: product from the multiplier, unsigned.
- `P_VALID`  in  1: `P_IN` is valid this cycle.
- `P_READY`  out  1: block accepts `P_IN` this cycle.
- `SUM`  out  `ACC_W`: finished block sum.
- `SUM_OVF`  out  1: carry out of `ACC_W` occurred during this block.
- `SUM_VALID`  out  1: `SUM` and `SUM_OVF` are valid.
- `SUM_READY`  in  1: downstream takes `SUM` this cycle.

## Operation
- **States:** `ACCUM` (accepting products) and `HOLD` (sum presented).
- **Reset values:** state = `ACCUM`, acc = 0, term count = 0, ovf = 0, `SUM` = 0, `SUM_OVF` = 0, `SUM_VALID` = 0.
- **`P_READY`:** combinational, equal to (state == `ACCUM`).
- **Accept:** occurs when `P_VALID` & `P_READY`.
  - On accept with count < `N_TERMS`−1: acc ← acc + zero-extended `P_IN` (modulo 2^`ACC_W`); ovf ← ovf | carry; count++.
  - On accept with count == `N_TERMS`−1 (the last term):
    - `SUM` ← acc + `P_IN`; `SUM_OVF` ← ovf | carry; `SUM_VALID` ← 1.
    - acc, count and ovf ← 0.
    - state ← `HOLD`.
- **`HOLD`:**
  - `SUM`, `SUM_OVF` and `SUM_VALID` are stable.
  - `P_VALID` is ignored and `P_IN` may change freely.
  - On `SUM_READY` the block clears `SUM_VALID` and returns to `ACCUM`.
  - `SUM` keeps its last value after the handshake; it is not cleared.
- **Arithmetic:** unsigned only; no saturation, sums wrap. The overflow flag is sticky within a block and clears when the block ends.
- **`N_TERMS` = 1:** every accepted product goes directly to `HOLD` with `SUM` = `P_IN`.
- **Term counter:** width is max(1, $clog2(`N_TERMS`)); it never exceeds `N_TERMS`−1.
- **Gaps:** `P_VALID` low in `ACCUM` leaves all state unchanged, so gaps between products are allowed.
- **Reset mid-block:** a partial sum is discarded and no `SUM_VALID` is produced for it.
- **Reset in `HOLD`:** the pending sum is dropped and `SUM_VALID` falls on the next edge.
- **Simultaneous `RESET` and handshake:** `RESET` wins.

## Timing
- **Latency:** `SUM_VALID` rises on the edge that accepts the last term, so it is visible one cycle after that accept cycle.
- **Bubble:** one cycle per block. `P_READY` is 0 throughout `HOLD`, including the cycle in which `SUM_READY` is sampled high. `P_READY` returns to 1 the cycle after the handshake.
- **Throughput:** with `SUM_READY` held at 1, one block completes every `N_TERMS` + 1 cycles.
- **Combinational paths:** no combinational path from `P_VALID` to `P_READY`, and none from `SUM_READY` to any output. The outputs, apart from `P_READY`, are registers.
- **Reset release:** `P_READY` = 1 in the first cycle after `RESET` falls.

## Structure
- **Shared package `prod_acc_pkg`:**
  - state enum {`ACCUM`, `HOLD`};
  - default-width constants `P_W` = 8 and `ACC_W` = 10, which are shared with the multiplier's bench.
- **Sub-module `acc_term_counter`:** a natural split.
  - Parameter `N_TERMS`.
  - Inputs: `CLK`, `RESET`, `inc`.
  - Outputs: `last` (count == `N_TERMS`−1) and `wrap`.
  - The top level holds the FSM, the adder and the output registers.

## Test plan
- **Basic block:** `RESET` high for 1 cycle, then 4 × `P_IN` = 99 (9 × 11) with `P_VALID` high every cycle → `SUM` = 396, `SUM_OVF` = 0, `SUM_VALID` high the cycle after the 4th accept; `P_READY` = 0 during `HOLD`.
- **Gaps and maximum values:** products 225, –, 225, –, –, 225, 225, where – is `P_VALID` = 0 → `SUM` = 900, `SUM_OVF` = 0. Gaps must not count as terms.
- **Backpressure:** `SUM_READY` held at 0 for 3 cycles in `HOLD` while `P_VALID` = 1 with `P_IN` = 1 →
  - `SUM` stays stable, and no input is accepted;
  - after `SUM_READY` = 1, `P_READY` returns the next cycle;
  - the next block sums only terms accepted after that point.
- **Reset mid-block:** accept 50 and 60, assert `RESET` for 1 cycle, then accept 1, 2, 3, 4 → `SUM` = 10. No output appears for the discarded partial block.
- **Overflow:** `N_TERMS` = 2, `ACC_W` = 8; products 225 and 225 → `SUM` = 194, `SUM_OVF` = 1. A following block of 1 + 1 → `SUM` = 2, `SUM_OVF` = 0.
- **`N_TERMS` = 1:** a stream of 3, 7, 9 with `SUM_READY` held at 1 → `SUM` = 3, 7, 9 in order, with one bubble cycle between accepts.
